// File: rtl/uart_fifo_periph.sv
// rtl/uart_fifo_periph.sv - memory-mapped UART with TX/RX FIFOs, status/control registers and interrupt
//
// Purpose: CPU-facing UART peripheral. A byte FIFO on each direction decouples
// software from the serial timing; a small TX FSM feeds the core one byte at a time.
// Ports (uart_fifo_periph):
//   clk, reset_i          system clock, asynchronous active-high reset
//   sel_i, we_i, addr_i   one register access per sel_i cycle; addr_i[3:2] picks the register
//   data_in_i/data_out_o  write data / combinational read data (0 when sel_i low)
//   irq_o                 registered level interrupt
//   rx_i, tx_o            serial line in / out (N-8-1, idle high)
// Register map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved (reads 0).

module uart_fifo_periph_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [7:0]              i_data,
  output logic [7:0]              o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is still
  // accepted when a pop frees the slot in the same cycle.
  assign w_pop      = i_pop && (r_count != '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_overflow = i_push && !w_push;
  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

module uart_fifo_periph_core #(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr,
  input  logic [7:0] i_tx_data,
  output logic       o_busy,
  output logic       o_tx,
  input  logic       i_rx,
  input  logic       i_rd,
  output logic [7:0] o_rx_data,
  output logic       o_valid
);
  localparam int CW = 16;

  logic [CW-1:0] r_tx_clk;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_shift;
  logic          r_tx_busy;
  logic [1:0]    r_rx_sync;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_clk;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_valid;
  logic          w_rx;

  assign o_busy    = r_tx_busy;
  assign o_tx      = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign w_rx      = r_rx_sync[1];
  assign o_rx_data = r_rx_data;
  assign o_valid   = r_valid;

  // Transmitter: shift {stop, data, start} out LSB first, one bit per DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_clk   <= '0;
      r_tx_bit   <= '0;
    end else if (!r_tx_busy) begin
      if (i_wr) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, i_tx_data, 1'b0};
        r_tx_clk   <= '0;
        r_tx_bit   <= '0;
      end
    end else if (r_tx_clk == CW'(DIV - 1)) begin
      r_tx_clk   <= '0;
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      r_tx_bit   <= r_tx_bit + 1'b1;
      if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
    end else begin
      r_tx_clk <= r_tx_clk + 1'b1;
    end
  end

  // Receiver: first wait half a bit to land mid start bit, then sample every DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_busy  <= 1'b0;
      r_rx_clk   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], i_rx};
      if (i_rd) r_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (!w_rx) begin
          r_rx_busy <= 1'b1;
          r_rx_clk  <= '0;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_clk == ((r_rx_bit == 4'd0) ? CW'(DIV / 2 - 1) : CW'(DIV - 1))) begin
        r_rx_clk <= '0;
        r_rx_bit <= r_rx_bit + 1'b1;
        if (r_rx_bit == 4'd0) begin
          if (w_rx) r_rx_busy <= 1'b0;   // start bit vanished: treat as a glitch
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (w_rx) begin                // framing error drops the byte
            r_valid   <= 1'b1;
            r_rx_data <= r_rx_shift;
          end
        end else begin
          r_rx_shift <= {w_rx, r_rx_shift[7:1]};
        end
      end else begin
        r_rx_clk <= r_rx_clk + 1'b1;
      end
    end
  end
endmodule

module uart_fifo_periph #(
  parameter int FREQ_HZ  = 12000000,
  parameter int BAUDS    = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        irq_o,
  input  logic        rx_i,
  output logic        tx_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

  tx_state_t                   r_state;
  tx_state_t                   w_state_next;
  logic [1:0]                  r_ctrl;
  logic                        r_tx_drop;
  logic                        r_rx_overrun;
  logic                        r_rx_rd;
  logic                        r_irq;
  logic                        w_wr, w_rd, w_data_sel, w_stat_sel, w_ctrl_sel;
  logic                        w_tx_push, w_tx_pop, w_tx_full, w_tx_ovf, w_tx_empty;
  logic                        w_rx_push, w_rx_pop, w_rx_full, w_rx_ovf, w_rx_valid;
  logic [7:0]                  w_tx_head, w_rx_head, w_core_rx_data;
  logic [$clog2(TX_DEPTH):0]   w_tx_count;
  logic [$clog2(RX_DEPTH):0]   w_rx_count;
  logic                        w_core_busy, w_core_valid;
  logic                        w_unused;

  assign w_wr       = sel_i & we_i;
  assign w_rd       = sel_i & ~we_i;
  assign w_data_sel = (addr_i[3:2] == 2'd0);
  assign w_stat_sel = (addr_i[3:2] == 2'd1);
  assign w_ctrl_sel = (addr_i[3:2] == 2'd2);
  assign w_unused   = &{1'b0, addr_i[1:0], data_in_i[31:8], w_rx_full};

  assign w_tx_push  = w_wr & w_data_sel;
  assign w_tx_pop   = (r_state == S_LOAD);
  assign w_tx_empty = (w_tx_count == '0);
  // Skip the cycle right after rd_i: the core's valid_o is still high then.
  assign w_rx_push  = w_core_valid & ~r_rx_rd;
  assign w_rx_pop   = w_rd & w_data_sel;
  assign w_rx_valid = (w_rx_count != '0);
  assign irq_o      = r_irq;

  uart_fifo_periph_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset_i), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(data_in_i[7:0]),
    .o_head(w_tx_head), .o_count(w_tx_count), .o_full(w_tx_full), .o_overflow(w_tx_ovf)
  );

  uart_fifo_periph_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset_i), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_data(w_core_rx_data),
    .o_head(w_rx_head), .o_count(w_rx_count), .o_full(w_rx_full), .o_overflow(w_rx_ovf)
  );

  uart_fifo_periph_core #(.DIV(FREQ_HZ / BAUDS)) u_core (
    .clk(clk), .rst(reset_i), .i_wr(w_tx_pop), .i_tx_data(w_tx_head), .o_busy(w_core_busy),
    .o_tx(tx_o), .i_rx(rx_i), .i_rd(r_rx_rd), .o_rx_data(w_core_rx_data), .o_valid(w_core_valid)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_tx_empty && !w_core_busy) w_state_next = S_LOAD;
      S_LOAD:      w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (w_core_busy) w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!w_core_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_ctrl       <= '0;
      r_tx_drop    <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_rd      <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rx_rd <= w_core_valid & ~r_rx_rd;
      if (w_wr && w_ctrl_sel) r_ctrl <= data_in_i[1:0];
      // A new error event in the clearing cycle keeps the flag set.
      r_tx_drop    <= w_tx_ovf | (r_tx_drop & ~(w_wr & w_stat_sel & data_in_i[4]));
      r_rx_overrun <= w_rx_ovf | (r_rx_overrun & ~(w_wr & w_stat_sel & data_in_i[3]));
      r_irq        <= (r_ctrl[0] & w_rx_valid) | (r_ctrl[1] & w_tx_empty & (r_state == S_IDLE));
    end
  end

  always_comb begin
    data_out_o = '0;
    if (sel_i) begin
      case (addr_i[3:2])
        2'd0:    data_out_o = {24'd0, (w_rx_valid ? w_rx_head : 8'd0)};
        2'd1:    data_out_o = {8'd0, 8'(w_rx_count), 8'(w_tx_count), 3'd0, r_tx_drop,
                               r_rx_overrun, w_tx_empty, w_rx_valid, w_tx_full};
        2'd2:    data_out_o = {30'd0, r_ctrl};
        default: data_out_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb/tb_uart_fifo_periph.sv - self-checking bench for uart_fifo_periph
module tb_uart_fifo_periph;
  localparam int FREQ = 8000000;
  localparam int BAUD = 1000000;
  localparam int DIV  = FREQ / BAUD;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        sel_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [31:0] data_in_i = '0;
  wire  [31:0] data_out_o;
  wire         irq_o;
  wire         tx_o;
  wire         rx_i;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        mon_en = 1'b1;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  assign rx_i = loop_en ? tx_o : rx_drv;

  uart_fifo_periph #(.FREQ_HZ(FREQ), .BAUDS(BAUD), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .reset_i(reset_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .data_in_i(data_in_i), .data_out_o(data_out_o), .irq_o(irq_o), .rx_i(rx_i), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial decoder on tx_o: each received frame is compared to the scoreboard head.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stop;
    forever begin
      @(negedge tx_o);
      if (mon_en && !reset_i) begin
        repeat (DIV / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1 b[i] = tx_o;
        end
        repeat (DIV) @(posedge clk);
        #1 stop = tx_o;
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_frame: got %02h, expected no frame", b);
        end else begin
          e = tx_q.pop_front();
          if (b !== e || stop !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_frame: got %02h stop %b, expected %02h stop 1", b, stop, e);
          end
        end
      end
    end
  end

  task automatic cpu(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    sel_i = 1'b1; we_i = we; addr_i = addr; data_in_i = wd;
    #1 rd = data_out_o;
    @(posedge clk);
    #1 sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = f[i];
      repeat (DIV - 1) @(negedge clk);
    end
  endtask

  task automatic wait_tx_drain(input int budget);
    int i;
    for (i = 0; i < budget && tx_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL tx_drain_timeout: %0d bytes pending, expected 0", tx_q.size());
    end
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (irq_o !== 1'b0 || tx_o !== 1'b1 || data_out_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pins: irq %b tx %b dout %h, expected 0 1 0", irq_o, tx_o, data_out_o);
    end
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h expected 00000004", rd); end
    cpu(1'b0, 4'h8, 0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    cpu(1'b0, 4'h0, 0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd); end
    cpu(1'b0, 4'hC, 0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      cpu(1'b1, 4'h0, 32'hFFFF_FF41 + i, rd);
    end
    wait_tx_drain(1000);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL b2b_status_after: got %h expected 00000004", rd); end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd;
    tx_q.push_back(8'h00);
    cpu(1'b1, 4'h0, 32'h0, rd);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'h60 + 8'(i));
      cpu(1'b1, 4'h0, 32'h60 + i, rd);
    end
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h0000_1011) begin n_fail++; $display("FAIL txfull_status: got %h expected 00001011", rd); end
    cpu(1'b1, 4'h4, 32'h10, rd);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h0000_1001) begin n_fail++; $display("FAIL txdrop_clear: got %h expected 00001001", rd); end
    wait_tx_drain(3000);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL txfull_drained: got %h expected 00000004", rd); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd;
    logic [7:0]  e;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_q.push_back(8'h80 + 8'(i * 3));
      send_byte(8'h80 + 8'(i * 3));
    end
    repeat (2 * DIV) @(negedge clk);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h0010_000E) begin n_fail++; $display("FAIL rxfull_status: got %h expected 0010000e", rd); end
    for (int i = 0; i < 16; i++) begin
      e = rx_q.pop_front();
      cpu(1'b0, 4'h0, 0, rd);
      n_cmp++;
      if (rd !== {24'd0, e}) begin
        n_fail++;
        $display("FAIL rx_read_%0d: got %h expected %h", i, rd, {24'd0, e});
      end
    end
    cpu(1'b0, 4'h0, 0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL rx_read_empty: got %h expected 0", rd); end
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'hC) begin n_fail++; $display("FAIL rx_overrun_sticky: got %h expected 0000000c", rd); end
    cpu(1'b1, 4'h4, 32'h8, rd);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL rx_overrun_clear: got %h expected 00000004", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic [31:0] st;
    logic        irq_a;
    logic        irq_b;
    logic        seen;
    cpu(1'b1, 4'h8, 32'h1, rd);
    rx_q.push_back(8'h55);
    fork
      send_byte(8'h55);
    join_none
    seen = 1'b0;
    irq_a = 1'bx;
    irq_b = 1'bx;
    for (int i = 0; i < 20 * DIV && !seen; i++) begin
      @(negedge clk);
      sel_i = 1'b1; we_i = 1'b0; addr_i = 4'h4;
      #1 st = data_out_o;
      irq_a = irq_o;
      @(posedge clk);
      #1 irq_b = irq_o;
      sel_i = 1'b0;
      seen = st[1];
    end
    n_cmp++;
    if (!seen || irq_a !== 1'b0 || irq_b !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx_rise: seen %b irq push-cycle %b next %b, expected 1 0 1", seen, irq_a, irq_b);
    end
    repeat (2 * DIV) @(negedge clk);
    cpu(1'b0, 4'h0, 0, rd);
    n_cmp++;
    if (rd !== {24'd0, rx_q.pop_front()}) begin n_fail++; $display("FAIL irq_rx_data: got %h expected 00000055", rd); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_rx_fall: got %b expected 0", irq_o); end
    cpu(1'b1, 4'h8, 32'h2, rd);
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_tx_idle: got %b expected 1", irq_o); end
    cpu(1'b0, 4'h8, 0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL ctrl_readback: got %h expected 00000002", rd); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    mon_en = 1'b0;
    loop_en = 1'b1;
    cpu(1'b1, 4'h0, 32'hA5, rd);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b0) begin n_fail++; $display("FAIL midframe_bit: tx %b expected 0", tx_o); end
    #2 reset_i = 1'b1;
    #1;
    n_cmp++;
    if (tx_o !== 1'b1 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: tx %b irq %b expected 1 0", tx_o, irq_o);
    end
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL midreset_status: got %h expected 00000004", rd); end
    cpu(1'b0, 4'h8, 0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl: got %h expected 0", rd); end
    repeat (20 * DIV) @(negedge clk);
    cpu(1'b0, 4'h4, 0, rd);
    n_cmp++;
    if (rd !== 32'h4 || tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_no_rx: status %h tx %b expected 00000004 1", rd, tx_o);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_tx_full();
    test_rx_overrun();
    test_irq();
    test_reset_midframe();
    n_cmp++;
    if (tx_q.size() != 0 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: tx %0d rx %0d expected 0 0", tx_q.size(), rx_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
